// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: FSM state type and streak-counter sizing shared by the arbiter files.
package unified_mem_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE_IF, RESP_IF, ISSUE_D, RESP_D} state_t;
  function automatic int streak_w(input int max);
    return $clog2(max + 1);
  endfunction
endpackage

// File: rtl/unified_mem_arbiter_streak.sv
// unified_mem_arbiter_streak: saturating count of back-to-back data grants made while a fetch waits.
module unified_mem_arbiter_streak #(
  parameter int MAX = 4,
  parameter int W   = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_max
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst | i_clr) ? '0 : (i_inc & ~o_max) ? r_cnt + W'(1) : r_cnt;
  assign o_max = r_cnt == W'(MAX);
endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one synchronous-read memory between fetch and load/store ports, data first.
// Defining MEM_ARB_STATS_EN adds grant/conflict counter ports.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 32,
  parameter int D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       stat_if_grants,
  output logic [31:0]       stat_d_grants,
  output logic [31:0]       stat_conflicts
`endif
);
  state_t              r_state, w_next;
  logic [ADDR_W-3:0]   r_addr;
  logic                r_we;
  logic [3:0]          r_be;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_idle, w_both, w_max, w_grant_d, w_grant_if, w_inc, w_unused;
  assign w_unused   = ^{if_addr[1:0], d_addr[1:0]};
  assign w_idle     = r_state == IDLE;
  assign w_both     = if_req & d_req;
  assign w_grant_d  = w_idle & d_req & ~(w_both & w_max);
  assign w_grant_if = w_idle & if_req & ~w_grant_d;
  assign w_inc      = w_grant_d & if_req;
  unified_mem_arbiter_streak #(
    .MAX(D_STREAK_MAX),
    .W  (streak_w(D_STREAK_MAX))
  ) u_streak (
    .clk  (clk),
    .rst  (rst),
    .i_inc(w_inc),
    .i_clr(w_idle & ~w_inc),
    .o_max(w_max)
  );
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state == ISSUE_IF ? RESP_IF :
             r_state == ISSUE_D  ? RESP_D  :
             w_grant_d           ? ISSUE_D :
             w_grant_if          ? ISSUE_IF : IDLE;
  end
  // Request fields are captured at grant; live inputs are ignored until the next IDLE.
  always_ff @(posedge clk)
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (w_grant_d) begin
      r_addr  <= d_addr[ADDR_W-1:2];
      r_we    <= d_we;
      r_be    <= d_be;
      r_wdata <= d_wdata;
    end else if (w_grant_if) begin
      r_addr  <= if_addr[ADDR_W-1:2];
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
    end
  always_comb begin
    mem_en    = ~rst & ((r_state == ISSUE_IF) | (r_state == ISSUE_D));
    mem_we    = mem_en & r_we;
    mem_be    = mem_en ? r_be : '0;
    mem_addr  = rst ? '0 : r_addr;
    mem_wdata = rst ? '0 : r_wdata;
    if_ack    = ~rst & (r_state == RESP_IF);
    d_ack     = ~rst & (r_state == RESP_D);
    if_rdata  = if_ack ? mem_rdata : '0;
    d_rdata   = d_ack ? mem_rdata : '0;
  end
`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_if_grants <= '0;
      stat_d_grants  <= '0;
      stat_conflicts <= '0;
    end else begin
      stat_if_grants <= stat_if_grants + 32'(w_grant_if);
      stat_d_grants  <= stat_d_grants + 32'(w_grant_d);
      stat_conflicts <= stat_conflicts + 32'(w_idle & w_both);
    end
`endif
endmodule
